dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; clock and reset ports SHALL be named clk and rst.
REQ-002 The block SHALL have parameter ADDR_W, default 12, giving word-address bits; memory depth SHALL be 2^ADDR_W 32-bit words.
REQ-003 The block SHALL have parameter INIT_ZERO, default 1; when 1, memory SHALL be zero at time 0 in simulation.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: asynchronous active-low reset.
REQ-006 Port req_valid, input, 1: request present.
REQ-007 Port req_ready, output, 1: request accepted when req_valid and req_ready are both high.
REQ-008 Port req_we, input, 1: 1 means store, 0 means load.
REQ-009 Port req_op, input, 3: access type; 000 word, 001 SH, 010 SB, 100 LH, 101 LHU, 110 LB, 111 LBU, 011 reserved.
REQ-010 Port req_addr, input, 32: byte address.
REQ-011 Port req_wdata, input, 32: store data, right-aligned.
REQ-012 Port rsp_valid, output, 1: response present.
REQ-013 Port rsp_ready, input, 1: response consumed when rsp_valid and rsp_ready are both high.
REQ-014 Port rsp_rdata, output, 32: load data, extended per req_op; 0 for stores and errors.
REQ-015 Port rsp_err, output, 1: access rejected.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a handshake SHALL capture we, op, addr and wdata into registers and move the FSM to ACCESS.
REQ-018 ACCESS SHALL perform exactly one RAM operation on the captured request, then move to RESP unconditionally.
REQ-019 RESP SHALL hold rsp_valid=1 with stable rsp_rdata and rsp_err until rsp_ready=1, then move to IDLE.
REQ-020 Latency: a request accepted at edge N SHALL give rsp_valid=1 after edge N+2; at most one request SHALL be outstanding.
REQ-021 Word index SHALL be addr[ADDR_W+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo depth.
REQ-022 SB SHALL write wdata[7:0] to byte lane addr[1:0]; other bytes SHALL be unchanged.
REQ-023 SH SHALL write wdata[15:0] to half lane addr[1]; other bytes SHALL be unchanged.
REQ-024 Word stores SHALL write all 4 bytes.
REQ-025 Loads SHALL select the addressed byte or half (shift by addr[1:0] or addr[1]) before sign or zero extension.
REQ-026 Loads with op 001 or 010 SHALL be treated as word loads.
REQ-027 A store with op 1xx SHALL be treated as reserved.
REQ-028 Reserved op (011, or 1xx with req_we=1) SHALL give rsp_err=1, perform no write, and give rsp_rdata=0.
REQ-029 A read in ACCESS SHALL return data including any store completed earlier; there SHALL be no stale-read hazard.
REQ-030 rsp_ready held high in advance SHALL give a single-cycle RESP.
REQ-031 req_valid asserted during ACCESS or RESP SHALL be ignored until IDLE.

Reset
REQ-032 rst low SHALL immediately force IDLE, req_ready=1 (after release), rsp_valid=0, rsp_rdata=0, rsp_err=0, and clear all captured request registers.
REQ-033 Reset asserted before the ACCESS edge SHALL abort the pending store without a write.
REQ-034 Reset SHALL not alter memory contents.
REQ-035 While rst is low, req_ready SHALL be 0.

Configuration
REQ-036 With macro DMEM_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL give rsp_err=1, no write, and rsp_rdata=0.
REQ-037 Without DMEM_MISALIGN_TRAP_EN, such accesses SHALL force natural alignment (ignore addr[0] for halves, addr[1:0] for words); rsp_err SHALL flag only reserved ops.

Verification
REQ-038 SW 0x11223344 @0x100, then LW @0x100 -> rsp_rdata=0x11223344, rsp_err=0, rsp_valid two cycles after each accept.
REQ-039 SB 0xAB @0x103 onto 0x11223344, then LW @0x100 -> 0xAB223344; LB @0x103 -> 0xFFFFFFAB; LBU -> 0x000000AB.
REQ-040 SH 0x8001 @0x102, then LH @0x102 -> 0xFFFF8001; LHU @0x102 -> 0x00008001; LW @0x100 -> 0x8001xxxx with lower half unchanged.
REQ-041 With trap: LW @0x101 -> rsp_err=1, rsp_rdata=0; SH @0x101 leaves memory unchanged. Without trap: LW @0x101 returns word @0x100.
REQ-042 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; assert rst during ACCESS of SW 0xDEADBEEF @0x200 -> LW @0x200 afterwards returns old value.
REQ-043 op=011 store @0x0 -> rsp_err=1, no write; SW @(0x4000+0x10) with ADDR_W=12 -> LW @0x10 returns the stored value (wrap).

Source files
------------

// File: rtl/dmem_ctrl.sv
// Single-port data memory controller: byte/half/word loads and stores over a
// valid/ready request and response pair. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_nx;
    logic                we_q;
    logic [2:0]          op_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO != 0) ? 32'h0 : 32'hx};

    logic                is_rsvd, is_byte, is_half, misalign, acc_err;
    logic [1:0]          lane;
    logic [ADDR_W-1:0]   idx;
    logic [31:0]         rd_word, rd_shift, ld_data, wr_data;
    logic [3:0]          wr_be;
    logic                unused_addr_bits;

    // Address bits above the memory depth are deliberately dropped (wrap).
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && rst;
        rsp_valid = (state == RESP);
    end

    // ---------------- request capture ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else if (req_valid && req_ready) begin
            we_q    <= req_we;
            op_q    <= req_op;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
        end
    end

    // ---------------- access decode ----------------
    always_comb begin
        is_rsvd = (op_q == 3'b011) || (we_q && op_q[2]);
        is_byte = we_q ? (op_q == 3'b010) : (op_q[2:1] == 2'b11);
        is_half = we_q ? (op_q == 3'b001) : (op_q[2:1] == 2'b10);
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (is_half && addr_q[0]) || (!is_byte && !is_half && (addr_q[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        acc_err = is_rsvd || misalign;
        // Halves and words are forced to their natural lane when not trapping.
        if (is_byte)      lane = addr_q[1:0];
        else if (is_half) lane = {addr_q[1], 1'b0};
        else              lane = 2'b00;
        idx = addr_q[ADDR_W+1:2];
    end

    // NOTE: asynchronous read of the array sees every earlier completed store.
    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        ld_data = 32'h0;
        if (!we_q && !acc_err) begin
            case (op_q)
                3'b100:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
                3'b101:  ld_data = {16'h0, rd_shift[15:0]};
                3'b110:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
                3'b111:  ld_data = {24'h0, rd_shift[7:0]};
                default: ld_data = rd_word;
            endcase
        end
    end

    always_comb begin
        if (is_byte) begin
            wr_be   = 4'b0001 << lane;
            wr_data = {4{wdata_q[7:0]}};
        end else if (is_half) begin
            wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{wdata_q[15:0]}};
        end else begin
            wr_be   = 4'b1111;
            wr_data = wdata_q;
        end
    end

    // NOTE: the array has no reset; a reset only stops the pending write.
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // ---------------- response ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_rdata <= ld_data;
            rsp_err   <= acc_err;
        end
    end

endmodule
